// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the iterative AES-128 cores.
// Holds the round count, the Rcon table, the FSM state enum, GF(2^8) helpers
// and the FIPS-197 byte-index mapping used by both cipher directions.
// Byte i of a 128-bit block sits at bits [127-8*i -: 8]; i = row + 4*col.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ROUND_W    = 4;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column-major state index of (row, col).
  function automatic logic [3:0] byte_idx(input int row, input int col);
    return 4'(row + 4 * col);
  endfunction

  // Extract byte i of a block.
  function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                          input int i);
    return blk[BLOCK_W-1-8*i -: 8];
  endfunction

  // Rcon for a round number; zero outside 1..10.
  function automatic logic [7:0] rcon_of(input logic [ROUND_W-1:0] rnd);
    logic [7:0] rc;
    rc = 8'h00;
    if (rnd >= 4'd1 && rnd <= 4'd10) rc = RCON[rnd];
    return rc;
  endfunction

  // Forward MixColumns on one column {a0,a1,a2,a3}.
  function automatic logic [WORD_W-1:0] mix_column(input logic [WORD_W-1:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    {a0, a1, a2, a3} = col;
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box.
// Ports: x   - input byte
//        y_c - substituted byte (combinational)
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y_c
);

  always_comb begin : sbox_lut
    y_c = 8'h00;
    unique case (x)
      8'h00: y_c = 8'h63; 8'h01: y_c = 8'h7c; 8'h02: y_c = 8'h77; 8'h03: y_c = 8'h7b; 8'h04: y_c = 8'hf2; 8'h05: y_c = 8'h6b; 8'h06: y_c = 8'h6f; 8'h07: y_c = 8'hc5;
      8'h08: y_c = 8'h30; 8'h09: y_c = 8'h01; 8'h0a: y_c = 8'h67; 8'h0b: y_c = 8'h2b; 8'h0c: y_c = 8'hfe; 8'h0d: y_c = 8'hd7; 8'h0e: y_c = 8'hab; 8'h0f: y_c = 8'h76;
      8'h10: y_c = 8'hca; 8'h11: y_c = 8'h82; 8'h12: y_c = 8'hc9; 8'h13: y_c = 8'h7d; 8'h14: y_c = 8'hfa; 8'h15: y_c = 8'h59; 8'h16: y_c = 8'h47; 8'h17: y_c = 8'hf0;
      8'h18: y_c = 8'had; 8'h19: y_c = 8'hd4; 8'h1a: y_c = 8'ha2; 8'h1b: y_c = 8'haf; 8'h1c: y_c = 8'h9c; 8'h1d: y_c = 8'ha4; 8'h1e: y_c = 8'h72; 8'h1f: y_c = 8'hc0;
      8'h20: y_c = 8'hb7; 8'h21: y_c = 8'hfd; 8'h22: y_c = 8'h93; 8'h23: y_c = 8'h26; 8'h24: y_c = 8'h36; 8'h25: y_c = 8'h3f; 8'h26: y_c = 8'hf7; 8'h27: y_c = 8'hcc;
      8'h28: y_c = 8'h34; 8'h29: y_c = 8'ha5; 8'h2a: y_c = 8'he5; 8'h2b: y_c = 8'hf1; 8'h2c: y_c = 8'h71; 8'h2d: y_c = 8'hd8; 8'h2e: y_c = 8'h31; 8'h2f: y_c = 8'h15;
      8'h30: y_c = 8'h04; 8'h31: y_c = 8'hc7; 8'h32: y_c = 8'h23; 8'h33: y_c = 8'hc3; 8'h34: y_c = 8'h18; 8'h35: y_c = 8'h96; 8'h36: y_c = 8'h05; 8'h37: y_c = 8'h9a;
      8'h38: y_c = 8'h07; 8'h39: y_c = 8'h12; 8'h3a: y_c = 8'h80; 8'h3b: y_c = 8'he2; 8'h3c: y_c = 8'heb; 8'h3d: y_c = 8'h27; 8'h3e: y_c = 8'hb2; 8'h3f: y_c = 8'h75;
      8'h40: y_c = 8'h09; 8'h41: y_c = 8'h83; 8'h42: y_c = 8'h2c; 8'h43: y_c = 8'h1a; 8'h44: y_c = 8'h1b; 8'h45: y_c = 8'h6e; 8'h46: y_c = 8'h5a; 8'h47: y_c = 8'ha0;
      8'h48: y_c = 8'h52; 8'h49: y_c = 8'h3b; 8'h4a: y_c = 8'hd6; 8'h4b: y_c = 8'hb3; 8'h4c: y_c = 8'h29; 8'h4d: y_c = 8'he3; 8'h4e: y_c = 8'h2f; 8'h4f: y_c = 8'h84;
      8'h50: y_c = 8'h53; 8'h51: y_c = 8'hd1; 8'h52: y_c = 8'h00; 8'h53: y_c = 8'hed; 8'h54: y_c = 8'h20; 8'h55: y_c = 8'hfc; 8'h56: y_c = 8'hb1; 8'h57: y_c = 8'h5b;
      8'h58: y_c = 8'h6a; 8'h59: y_c = 8'hcb; 8'h5a: y_c = 8'hbe; 8'h5b: y_c = 8'h39; 8'h5c: y_c = 8'h4a; 8'h5d: y_c = 8'h4c; 8'h5e: y_c = 8'h58; 8'h5f: y_c = 8'hcf;
      8'h60: y_c = 8'hd0; 8'h61: y_c = 8'hef; 8'h62: y_c = 8'haa; 8'h63: y_c = 8'hfb; 8'h64: y_c = 8'h43; 8'h65: y_c = 8'h4d; 8'h66: y_c = 8'h33; 8'h67: y_c = 8'h85;
      8'h68: y_c = 8'h45; 8'h69: y_c = 8'hf9; 8'h6a: y_c = 8'h02; 8'h6b: y_c = 8'h7f; 8'h6c: y_c = 8'h50; 8'h6d: y_c = 8'h3c; 8'h6e: y_c = 8'h9f; 8'h6f: y_c = 8'ha8;
      8'h70: y_c = 8'h51; 8'h71: y_c = 8'ha3; 8'h72: y_c = 8'h40; 8'h73: y_c = 8'h8f; 8'h74: y_c = 8'h92; 8'h75: y_c = 8'h9d; 8'h76: y_c = 8'h38; 8'h77: y_c = 8'hf5;
      8'h78: y_c = 8'hbc; 8'h79: y_c = 8'hb6; 8'h7a: y_c = 8'hda; 8'h7b: y_c = 8'h21; 8'h7c: y_c = 8'h10; 8'h7d: y_c = 8'hff; 8'h7e: y_c = 8'hf3; 8'h7f: y_c = 8'hd2;
      8'h80: y_c = 8'hcd; 8'h81: y_c = 8'h0c; 8'h82: y_c = 8'h13; 8'h83: y_c = 8'hec; 8'h84: y_c = 8'h5f; 8'h85: y_c = 8'h97; 8'h86: y_c = 8'h44; 8'h87: y_c = 8'h17;
      8'h88: y_c = 8'hc4; 8'h89: y_c = 8'ha7; 8'h8a: y_c = 8'h7e; 8'h8b: y_c = 8'h3d; 8'h8c: y_c = 8'h64; 8'h8d: y_c = 8'h5d; 8'h8e: y_c = 8'h19; 8'h8f: y_c = 8'h73;
      8'h90: y_c = 8'h60; 8'h91: y_c = 8'h81; 8'h92: y_c = 8'h4f; 8'h93: y_c = 8'hdc; 8'h94: y_c = 8'h22; 8'h95: y_c = 8'h2a; 8'h96: y_c = 8'h90; 8'h97: y_c = 8'h88;
      8'h98: y_c = 8'h46; 8'h99: y_c = 8'hee; 8'h9a: y_c = 8'hb8; 8'h9b: y_c = 8'h14; 8'h9c: y_c = 8'hde; 8'h9d: y_c = 8'h5e; 8'h9e: y_c = 8'h0b; 8'h9f: y_c = 8'hdb;
      8'ha0: y_c = 8'he0; 8'ha1: y_c = 8'h32; 8'ha2: y_c = 8'h3a; 8'ha3: y_c = 8'h0a; 8'ha4: y_c = 8'h49; 8'ha5: y_c = 8'h06; 8'ha6: y_c = 8'h24; 8'ha7: y_c = 8'h5c;
      8'ha8: y_c = 8'hc2; 8'ha9: y_c = 8'hd3; 8'haa: y_c = 8'hac; 8'hab: y_c = 8'h62; 8'hac: y_c = 8'h91; 8'had: y_c = 8'h95; 8'hae: y_c = 8'he4; 8'haf: y_c = 8'h79;
      8'hb0: y_c = 8'he7; 8'hb1: y_c = 8'hc8; 8'hb2: y_c = 8'h37; 8'hb3: y_c = 8'h6d; 8'hb4: y_c = 8'h8d; 8'hb5: y_c = 8'hd5; 8'hb6: y_c = 8'h4e; 8'hb7: y_c = 8'ha9;
      8'hb8: y_c = 8'h6c; 8'hb9: y_c = 8'h56; 8'hba: y_c = 8'hf4; 8'hbb: y_c = 8'hea; 8'hbc: y_c = 8'h65; 8'hbd: y_c = 8'h7a; 8'hbe: y_c = 8'hae; 8'hbf: y_c = 8'h08;
      8'hc0: y_c = 8'hba; 8'hc1: y_c = 8'h78; 8'hc2: y_c = 8'h25; 8'hc3: y_c = 8'h2e; 8'hc4: y_c = 8'h1c; 8'hc5: y_c = 8'ha6; 8'hc6: y_c = 8'hb4; 8'hc7: y_c = 8'hc6;
      8'hc8: y_c = 8'he8; 8'hc9: y_c = 8'hdd; 8'hca: y_c = 8'h74; 8'hcb: y_c = 8'h1f; 8'hcc: y_c = 8'h4b; 8'hcd: y_c = 8'hbd; 8'hce: y_c = 8'h8b; 8'hcf: y_c = 8'h8a;
      8'hd0: y_c = 8'h70; 8'hd1: y_c = 8'h3e; 8'hd2: y_c = 8'hb5; 8'hd3: y_c = 8'h66; 8'hd4: y_c = 8'h48; 8'hd5: y_c = 8'h03; 8'hd6: y_c = 8'hf6; 8'hd7: y_c = 8'h0e;
      8'hd8: y_c = 8'h61; 8'hd9: y_c = 8'h35; 8'hda: y_c = 8'h57; 8'hdb: y_c = 8'hb9; 8'hdc: y_c = 8'h86; 8'hdd: y_c = 8'hc1; 8'hde: y_c = 8'h1d; 8'hdf: y_c = 8'h9e;
      8'he0: y_c = 8'he1; 8'he1: y_c = 8'hf8; 8'he2: y_c = 8'h98; 8'he3: y_c = 8'h11; 8'he4: y_c = 8'h69; 8'he5: y_c = 8'hd9; 8'he6: y_c = 8'h8e; 8'he7: y_c = 8'h94;
      8'he8: y_c = 8'h9b; 8'he9: y_c = 8'h1e; 8'hea: y_c = 8'h87; 8'heb: y_c = 8'he9; 8'hec: y_c = 8'hce; 8'hed: y_c = 8'h55; 8'hee: y_c = 8'h28; 8'hef: y_c = 8'hdf;
      8'hf0: y_c = 8'h8c; 8'hf1: y_c = 8'ha1; 8'hf2: y_c = 8'h89; 8'hf3: y_c = 8'h0d; 8'hf4: y_c = 8'hbf; 8'hf5: y_c = 8'he6; 8'hf6: y_c = 8'h42; 8'hf7: y_c = 8'h68;
      8'hf8: y_c = 8'h41; 8'hf9: y_c = 8'h99; 8'hfa: y_c = 8'h2d; 8'hfb: y_c = 8'h0f; 8'hfc: y_c = 8'hb0; 8'hfd: y_c = 8'h54; 8'hfe: y_c = 8'hbb; 8'hff: y_c = 8'h16;
      default: y_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128 encryption, one round per clock with
// on-the-fly key expansion. Accept edge loads the initial AddRoundKey; rounds
// complete on the following 10 edges; ciphertext is then held until taken.
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready/in_data/in_key   - plaintext + key handshake
//        out_valid/out_ready/out_data       - ciphertext handshake
//        last_key                           - round-10 key (AES_LAST_KEY_OUT_EN)
// Build option: define AES_LAST_KEY_OUT_EN to add the last_key port/register.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [BLOCK_W-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data
`ifdef AES_LAST_KEY_OUT_EN
  ,
  output logic [BLOCK_W-1:0] last_key
`endif
);

  aes_fsm_e             fsm_q, fsm_d;
  logic [BLOCK_W-1:0]   state_reg, state_d;
  logic [BLOCK_W-1:0]   key_reg, key_d;
  logic [ROUND_W-1:0]   round, round_d;
  logic                 in_ready_d, out_valid_d;
  logic                 round10_done;

  // SubBytes on the round state.
  logic [7:0] sub_bytes [16];
  for (genvar g = 0; g < 16; g++) begin : g_state_sbox
    aes_sbox u_sbox (
      .x   (state_reg[BLOCK_W-1-8*g -: 8]),
      .y_c (sub_bytes[g])
    );
  end

  // Key expansion: SubWord(RotWord(w3)) feeds the next round key.
  logic [WORD_W-1:0]  w0, w1, w2, w3, rot_w, sub_w, tmp_w;
  logic [WORD_W-1:0]  n0, n1, n2, n3;
  logic [BLOCK_W-1:0] next_key;

  assign {w0, w1, w2, w3} = key_reg;
  assign rot_w            = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox u_sbox (
      .x   (rot_w[WORD_W-1-8*g -: 8]),
      .y_c (sub_w[WORD_W-1-8*g -: 8])
    );
  end

  assign tmp_w    = sub_w ^ {rcon_of(round), 24'h000000};
  assign n0       = w0 ^ tmp_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // ShiftRows (row r rotates left by r) then MixColumns per column.
  logic [BLOCK_W-1:0] sr_flat, mc_flat;

  always_comb begin : shift_mix
    sr_flat = '0;
    mc_flat = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_flat[BLOCK_W-1-8*(r+4*c) -: 8] = sub_bytes[byte_idx(r, (c + r) % 4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_flat[BLOCK_W-1-32*c -: 32] = mix_column(sr_flat[BLOCK_W-1-32*c -: 32]);
    end
  end

  assign round10_done = (fsm_q == ST_RUN) && (round == ROUND_W'(NUM_ROUNDS));

  // FSM next-state and datapath next values.
  always_comb begin : fsm_next
    fsm_d       = fsm_q;
    state_d     = state_reg;
    key_d       = key_reg;
    round_d     = round;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = in_data ^ in_key;
          key_d   = in_key;
          round_d = ROUND_W'(1);
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        key_d = next_key;
        if (round10_done) begin
          state_d = sr_flat ^ next_key;
          fsm_d   = ST_DONE;
        end else begin
          state_d = mc_flat ^ next_key;
          round_d = round + ROUND_W'(1);
        end
      end
      ST_DONE: begin
        if (out_valid && out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
    // Handshake flags are decoded from the next state and registered.
    in_ready_d  = (fsm_d == ST_IDLE);
    out_valid_d = (fsm_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
    if (!rst_n) begin
      fsm_q     <= ST_IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      round     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_reg <= state_d;
      key_reg   <= key_d;
      round     <= round_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  assign out_data = state_reg;

`ifdef AES_LAST_KEY_OUT_EN
  // Round-10 key capture; persists across later blocks until the next one.
  always_ff @(posedge clk or negedge rst_n) begin : last_key_reg
    if (!rst_n) begin
      last_key <= '0;
    end else if (round10_done) begin
      last_key <= next_key;
    end
  end
`endif

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter with an algorithmic AES reference.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
`ifdef AES_LAST_KEY_OUT_EN
  logic [127:0] last_key;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  aes_encrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef AES_LAST_KEY_OUT_EN
    ,
    .last_key  (last_key)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from multiplicative inverse plus affine transform.
  task automatic build_sbox();
    logic [7:0] inv, v, s;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      s = inv; v = inv;
      for (int k = 0; k < 4; k++) begin
        v = {v[6:0], v[7]};
        s = s ^ v;
      end
      sbox_t[b] = s ^ 8'h63;
    end
  endtask

  task automatic model_aes(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] lk);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    lk = {w[40], w[41], w[42], w[43]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic send_block(input logic [127:0] pt, input logic [127:0] key, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    in_valid = 1'b1; in_data = pt; in_key = key;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) return;
    end
    lat = -1;
  endtask

  task automatic take_output();
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
`ifdef AES_LAST_KEY_OUT_EN
    n_tests++; if (last_key !== 128'h0) begin n_fail++; $display("FAIL reset_last_key: got %h expected 0", last_key); end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fips_vectors();
    logic [127:0] pts [2], keys [2], cts [2], lks [2];
    logic [127:0] mct, mlk;
    bit ok; int lat;
    pts[0]  = 128'h3243f6a8885a308d313198a2e0370734; keys[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    cts[0]  = 128'h3925841d02dc09fbdc118597196a0b32; lks[0]  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    pts[1]  = 128'h00112233445566778899aabbccddeeff; keys[1] = 128'h000102030405060708090a0b0c0d0e0f;
    cts[1]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; lks[1]  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    for (int v = 0; v < 2; v++) begin
      model_aes(pts[v], keys[v], mct, mlk);
      send_block(pts[v], keys[v], ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL fips_accept[%0d]: in_ready never rose", v); end
      wait_valid(lat);
      n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL fips_latency[%0d]: got %0d expected 10", v, lat); end
      n_tests++; if (out_data !== cts[v]) begin n_fail++; $display("FAIL fips_ct[%0d]: got %h expected %h", v, out_data, cts[v]); end
      n_tests++; if (out_data !== mct) begin n_fail++; $display("FAIL fips_ct_model[%0d]: got %h expected %h", v, out_data, mct); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fips_ready_in_done[%0d]: got %b expected 0", v, in_ready); end
`ifdef AES_LAST_KEY_OUT_EN
      n_tests++; if (last_key !== lks[v]) begin n_fail++; $display("FAIL fips_last_key[%0d]: got %h expected %h", v, last_key, lks[v]); end
`endif
      take_output();
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL fips_after_take[%0d]: got valid=%b ready=%b expected 0/1", v, out_valid, in_ready); end
    end
  endtask

  task automatic test_random();
    logic [127:0] pt, key, mct, mlk;
    bit ok; int lat;
    for (int k = 0; k < 10; k++) begin
      pt = rand128(); key = rand128();
      model_aes(pt, key, mct, mlk);
      send_block(pt, key, ok);
      wait_valid(lat);
      n_tests++; if (out_data !== mct || lat !== 10) begin n_fail++; $display("FAIL random_ct[%0d]: got %h lat %0d expected %h lat 10", k, out_data, lat, mct); end
`ifdef AES_LAST_KEY_OUT_EN
      n_tests++; if (last_key !== mlk) begin n_fail++; $display("FAIL random_last_key[%0d]: got %h expected %h", k, last_key, mlk); end
`endif
      take_output();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, key, mct, mlk;
    bit ok; int lat;
    pt = rand128(); key = rand128();
    model_aes(pt, key, mct, mlk);
    send_block(pt, key, ok);
    wait_valid(lat);
    n_tests++; if (out_data !== mct) begin n_fail++; $display("FAIL bp_ct: got %h expected %h", out_data, mct); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'(($urandom() >> 3) & 1);
      in_data = rand128(); in_key = rand128();
      n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== mct) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b ready=%b data=%h expected 1/0/%h", c, out_valid, in_ready, out_data, mct);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    repeat (12) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_ghost: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt, key, mct, mlk;
    int acc [$];
    logic [127:0] got [$];
    int cyc;
    pt = 128'h00112233445566778899aabbccddeeff; key = 128'h000102030405060708090a0b0c0d0e0f;
    model_aes(pt, key, mct, mlk);
    cyc = 0;
    @(negedge clk);
    in_data = pt; in_key = key; in_valid = 1'b1; out_ready = 1'b1;
    while ((acc.size() < 2 || got.size() < 2) && cyc < 80) begin
      if (in_valid && in_ready) acc.push_back(cyc);
      if (out_valid && out_ready) got.push_back(out_data);
      @(posedge clk);
      #1 cyc++;
      if (acc.size() == 2) in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++; if (acc.size() !== 2 || got.size() !== 2) begin n_fail++; $display("FAIL b2b_counts: got %0d accepts %0d outputs expected 2/2", acc.size(), got.size()); end
    else begin
      n_tests++; if (acc[1] - acc[0] !== 12) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 12", acc[1] - acc[0]); end
      n_tests++; if (got[0] !== mct || got[1] !== mct) begin n_fail++; $display("FAIL b2b_ct: got %h %h expected %h", got[0], got[1], mct); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] pt, key, mct, mlk;
    bit ok; int lat;
    pt = 128'h3243f6a8885a308d313198a2e0370734; key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_aes(pt, key, mct, mlk);
    send_block(rand128(), rand128(), ok);
    repeat (4) @(posedge clk);
    #2;
    n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pre: got ready=%b valid=%b expected 0/0", in_ready, out_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0) begin
      n_fail++; $display("FAIL rst_async: got ready=%b valid=%b data=%h expected 1/0/0", in_ready, out_valid, out_data);
    end
`ifdef AES_LAST_KEY_OUT_EN
    n_tests++; if (last_key !== 128'h0) begin n_fail++; $display("FAIL rst_last_key: got %h expected 0", last_key); end
`endif
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard: got valid=%b expected 0", out_valid); end
    send_block(pt, key, ok);
    wait_valid(lat);
    n_tests++; if (out_data !== 128'h3925841d02dc09fbdc118597196a0b32 || lat !== 10) begin
      n_fail++; $display("FAIL rst_recover: got %h lat %0d expected %h lat 10", out_data, lat, mct);
    end
    take_output();
  endtask

  task automatic test_input_stability();
    logic [127:0] pt, key, mct, mlk;
    bit ok; int lat;
    pt = rand128(); key = rand128();
    model_aes(pt, key, mct, mlk);
    send_block(pt, key, ok);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      in_data = rand128(); in_key = rand128();
      @(posedge clk);
      #1 lat++;
    end
    n_tests++; if (out_data !== mct || lat !== 10) begin n_fail++; $display("FAIL stability_ct: got %h lat %0d expected %h lat 10", out_data, lat, mct); end
`ifdef AES_LAST_KEY_OUT_EN
    n_tests++; if (last_key !== mlk) begin n_fail++; $display("FAIL stability_last_key: got %h expected %h", last_key, mlk); end
`endif
    take_output();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_vectors();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_input_stability();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
